neuron_op_sequencer: RTL and testbench
======================================

// Module: neuron_op_sequencer
// PURPOSE
// Command-driven controller for one bit_serial_neuron. Accepts a BIND (HDC XOR) or INTEGRATE (SNN) job.
// Sets the neuron mode, pulses start, streams operand bits one per cycle and captures each result bit.
// Returns the assembled HV_DIM-bit result and a fire count over a valid/ready response channel.
// Sits between the HDC/SNN job dispatcher and a single neuron instance.
// PARAMETERS
// HV_DIM       64  hypervector / stream length in bits (>=2)
// THRESH_WIDTH 16  neuron threshold width
// OUT_LAT      1   cycles from an in_valid cycle to the cycle its result appears on state_bit_out/fire_event (1..4)
// LEN_W        $clog2(HV_DIM+1)  width of cmd_len and rsp_fire_cnt
// PORTS
// clk            in   1             single clock, all logic on posedge
// rst_n          in   1             synchronous, active-low reset
// cmd_valid      in   1             job request
// cmd_ready      out  1             = rst_n && state==IDLE && !abort
// cmd_op         in   1             0=BIND, 1=INTEGRATE
// cmd_a          in   HV_DIM        weight_bit stream source, bit 0 first
// cmd_b          in   HV_DIM        state_bit_in stream source, bit 0 first
// cmd_len        in   LEN_W         bits to stream; 0 or >HV_DIM means HV_DIM (BIND always streams HV_DIM)
// cmd_threshold  in   THRESH_WIDTH  latched into threshold at accept
// abort          in   1             cancel the current job, no response produced
// rsp_valid      out  1             result available, held until rsp_ready
// rsp_ready      in   1             consumer accepts the result
// rsp_hv         out  HV_DIM        BIND: captured state_bit_out per bit; INTEGRATE: captured fire_event per bit
// rsp_fire_cnt   out  LEN_W         count of captured fire_event=1
// busy           out  1             state != IDLE
// n_mode_hdc     out  1             to neuron mode_hdc
// n_in_valid     out  1             to neuron in_valid
// n_weight_bit   out  1             to neuron weight_bit
// n_state_bit    out  1             to neuron state_bit_in
// n_start        out  1             to neuron start
// n_threshold    out  THRESH_WIDTH  to neuron threshold
// n_state_bit_out in  1             from neuron
// n_fire_event   in   1             from neuron
// BEHAVIOUR
// - Reset: state=IDLE; n_mode_hdc, n_in_valid, n_weight_bit, n_state_bit, n_start, rsp_valid, busy = 0.
//   Reset also clears n_threshold=0, rsp_hv=0, rsp_fire_cnt=0, the OUT_LAT delay line and the bit index.
// - All n_* outputs and rsp_* outputs are registered.
// - FSM IDLE -> SETUP -> STREAM -> DRAIN -> RESP -> IDLE.
// - IDLE: accept when cmd_valid && cmd_ready. Latch op, a, b, eff_len and threshold. Clear rsp_hv and rsp_fire_cnt.
//   Set n_mode_hdc = (op==BIND). On accept, go to SETUP.
// - SETUP: 1 cycle; n_start=1 only for INTEGRATE; n_in_valid=0. Next state is STREAM.
// - STREAM: eff_len consecutive cycles. Cycle k drives n_in_valid=1, n_weight_bit=a[k], n_state_bit=b[k].
//   After the cycle with k=eff_len-1, go to DRAIN.
// - Capture: n_in_valid and k feed an OUT_LAT-deep delay line. In any cycle where its last stage is valid with index j:
//   rsp_hv[j] <= (BIND ? n_state_bit_out : n_fire_event).
//   INTEGRATE: rsp_fire_cnt += n_fire_event, saturating at 2^LEN_W-1.
// - DRAIN: exactly OUT_LAT cycles, n_in_valid=0, then RESP. The last capture occurs in the final DRAIN cycle.
// - RESP: rsp_valid=1, rsp_hv/rsp_fire_cnt stable. Leave to IDLE on rsp_valid && rsp_ready.
//   A new command can be accepted from the following cycle.
// - Latency (OUT_LAT=L): accept edge in cycle T gives rsp_valid first high in cycle T+eff_len+L+2.
// - n_mode_hdc changes only at accept; it is held from SETUP through RESP.
//   It keeps its last value in IDLE, so the neuron is never mode-switched mid-stream.
// - abort: in any state other than IDLE, return to IDLE on the next edge.
//   n_in_valid, n_start and rsp_valid drop to 0 and the delay line clears. No response; a pending rsp_valid is withdrawn.
//   In IDLE, abort only forces cmd_ready=0.
// - rst_n low mid-job: identical to abort, plus the full reset values above.
// - Bits beyond eff_len in rsp_hv remain 0.
// - rsp_ready high while not in RESP is ignored.
// TESTING
// 1 BIND, HV_DIM=64, L=1, a=64'hDEADBEEF_01234567, b=64'h0F0F0F0F_F0F0F0F0, model neuron XOR.
//   Expect rsp_hv=a^b, rsp_fire_cnt=0, rsp_valid at T+67.
// 2 INTEGRATE, len=20, a=b=all-ones, threshold=10, model fires on accumulated count>=10.
//   Expect one n_start pulse in SETUP, exactly 20 n_in_valid cycles, and rsp_fire_cnt/rsp_hv matching the model.
// 3 Back-to-back INTEGRATE then BIND: n_mode_hdc 0->1 only at the second accept, never while n_in_valid=1.
//   BIND of a=1,b=0 gives rsp_hv[0]=1.
// 4 Backpressure: rsp_ready=0 for 10 cycles. rsp_valid and data are held, cmd_ready=0; cmd_valid is not accepted until 1 cycle after rsp_ready.
// 5 abort asserted at stream bit 30: n_in_valid=0 next cycle, no rsp_valid.
//   The next BIND completes correctly with rsp_hv bits not polluted by the aborted job.
// 6 rst_n low for 1 cycle mid-DRAIN with L=3: all outputs reach reset values next cycle; cmd_ready=1 once rst_n high.

Source files
------------

// File: rtl/neuron_op_sequencer_if.sv
// Job command / response channel between the HDC/SNN dispatcher (master) and the neuron sequencer (slave).
// Valid/ready on both directions; abort travels with the command side.
interface neuron_op_sequencer_if #(
    parameter int HV_DIM       = 64,
    parameter int THRESH_WIDTH = 16,
    parameter int LEN_W        = $clog2(HV_DIM + 1)
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_op;
    logic [HV_DIM-1:0]       cmd_a;
    logic [HV_DIM-1:0]       cmd_b;
    logic [LEN_W-1:0]        cmd_len;
    logic [THRESH_WIDTH-1:0] cmd_threshold;
    logic                    abort;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [HV_DIM-1:0]       rsp_hv;
    logic [LEN_W-1:0]        rsp_fire_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_len, cmd_threshold, abort, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hv, rsp_fire_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_len, cmd_threshold, abort, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hv, rsp_fire_cnt
    );
endinterface

// File: rtl/neuron_op_sequencer.sv
// Drives one bit-serial neuron through a BIND or INTEGRATE job; response after eff_len+OUT_LAT+2 cycles.
// Response held until rsp_ready; no new command is taken until the cycle after the response handshake.
module neuron_op_sequencer #(
    parameter int HV_DIM       = 64,
    parameter int THRESH_WIDTH = 16,
    parameter int OUT_LAT      = 1,
    parameter int LEN_W        = $clog2(HV_DIM + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    neuron_op_sequencer_if.slave    s_if,
    output logic                    o_busy,
    output logic                    o_n_mode_hdc,
    output logic                    o_n_in_valid,
    output logic                    o_n_weight_bit,
    output logic                    o_n_state_bit,
    output logic                    o_n_start,
    output logic [THRESH_WIDTH-1:0] o_n_threshold,
    input  logic                    i_n_state_bit_out,
    input  logic                    i_n_fire_event
);
    localparam int IDX_W = $clog2(HV_DIM);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STREAM, S_DRAIN, S_RESP} state_t;
    state_t r_state, w_next;

    logic                    r_op;
    logic [HV_DIM-1:0]       r_a, r_b;
    logic [LEN_W-1:0]        r_len, r_idx;
    logic [IDX_W-1:0]        r_out_idx;
    logic [2:0]              r_drain;
    logic [OUT_LAT-1:0]      r_dl_vld;
    logic [IDX_W-1:0]        r_dl_idx [OUT_LAT];
    logic                    r_n_mode_hdc, r_n_in_valid, r_n_weight_bit, r_n_state_bit, r_n_start;
    logic [THRESH_WIDTH-1:0] r_n_threshold;
    logic                    r_rsp_valid;
    logic [HV_DIM-1:0]       r_rsp_hv;
    logic [LEN_W-1:0]        r_fire_cnt;

    logic                    w_accept, w_abort, w_emit, w_cap_vld;
    logic [IDX_W-1:0]        w_cap_idx;
    logic [LEN_W-1:0]        w_eff_len;

    assign s_if.cmd_ready    = i_rst_n && (r_state == S_IDLE) && !s_if.abort;
    assign w_accept          = s_if.cmd_valid && s_if.cmd_ready;
    assign w_abort           = s_if.abort && (r_state != S_IDLE);
    // Emitting a bit for next cycle is exactly "next cycle is a STREAM cycle".
    assign w_emit            = (w_next == S_STREAM);
    assign w_cap_vld         = r_dl_vld[OUT_LAT-1];
    assign w_cap_idx         = r_dl_idx[OUT_LAT-1];

    assign s_if.rsp_valid    = r_rsp_valid;
    assign s_if.rsp_hv       = r_rsp_hv;
    assign s_if.rsp_fire_cnt = r_fire_cnt;
    assign o_busy            = (r_state != S_IDLE);
    assign o_n_mode_hdc      = r_n_mode_hdc;
    assign o_n_in_valid      = r_n_in_valid;
    assign o_n_weight_bit    = r_n_weight_bit;
    assign o_n_state_bit     = r_n_state_bit;
    assign o_n_start         = r_n_start;
    assign o_n_threshold     = r_n_threshold;

    always_comb begin
        w_eff_len = s_if.cmd_len;
        if (!s_if.cmd_op || s_if.cmd_len == '0 || 32'(s_if.cmd_len) > HV_DIM)
            w_eff_len = LEN_W'(HV_DIM);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_STREAM;
            S_STREAM: if (r_idx == r_len) w_next = S_DRAIN;
            S_DRAIN:  if (r_drain == 3'(OUT_LAT - 1)) w_next = S_RESP;
            S_RESP:   if (s_if.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op           <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_len          <= '0;
            r_idx          <= '0;
            r_out_idx      <= '0;
            r_drain        <= '0;
            r_dl_vld       <= '0;
            for (int i = 0; i < OUT_LAT; i++) r_dl_idx[i] <= '0;
            r_n_mode_hdc   <= 1'b0;
            r_n_in_valid   <= 1'b0;
            r_n_weight_bit <= 1'b0;
            r_n_state_bit  <= 1'b0;
            r_n_start      <= 1'b0;
            r_n_threshold  <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_hv       <= '0;
            r_fire_cnt     <= '0;
        end else begin
            r_n_start    <= w_accept && s_if.cmd_op;
            r_n_in_valid <= w_emit;
            r_rsp_valid  <= (w_next == S_RESP);

            if (w_accept) begin
                r_op          <= s_if.cmd_op;
                r_a           <= s_if.cmd_a;
                r_b           <= s_if.cmd_b;
                r_len         <= w_eff_len;
                r_idx         <= '0;
                r_drain       <= '0;
                r_n_threshold <= s_if.cmd_threshold;
                r_n_mode_hdc  <= !s_if.cmd_op;
                r_rsp_hv      <= '0;
                r_fire_cnt    <= '0;
            end else if (w_cap_vld) begin
                r_rsp_hv[w_cap_idx] <= r_op ? i_n_fire_event : i_n_state_bit_out;
                if (r_op && r_fire_cnt != '1)
                    r_fire_cnt <= r_fire_cnt + LEN_W'(i_n_fire_event);
            end

            // Operands shift out LSB-first so the bit driven never needs a variable index.
            if (w_emit) begin
                r_n_weight_bit <= r_a[0];
                r_n_state_bit  <= r_b[0];
                r_a            <= r_a >> 1;
                r_b            <= r_b >> 1;
                r_out_idx      <= r_idx[IDX_W-1:0];
                r_idx          <= r_idx + LEN_W'(1);
            end

            if (r_state == S_DRAIN) r_drain <= r_drain + 3'd1;

            for (int i = OUT_LAT - 1; i > 0; i--) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_idx[i] <= r_dl_idx[i-1];
            end
            r_dl_vld[0] <= r_n_in_valid;
            r_dl_idx[0] <= r_out_idx;
            if (w_abort) r_dl_vld <= '0;
        end
    end
endmodule

// File: tb/tb_neuron_op_sequencer.sv
`timescale 1ns/1ps
module tb_neuron_op_sequencer;
    localparam int HV_DIM = 64;
    localparam int TW     = 16;
    localparam int L      = 3;
    localparam int LEN_W  = $clog2(HV_DIM + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_op_sequencer_if #(.HV_DIM(HV_DIM), .THRESH_WIDTH(TW), .LEN_W(LEN_W)) bus();

    logic          busy, n_mode_hdc, n_in_valid, n_weight_bit, n_state_bit, n_start;
    logic [TW-1:0] n_threshold;
    logic          n_sbo, n_fire;

    neuron_op_sequencer #(.HV_DIM(HV_DIM), .THRESH_WIDTH(TW), .OUT_LAT(L), .LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(bus), .o_busy(busy),
        .o_n_mode_hdc(n_mode_hdc), .o_n_in_valid(n_in_valid), .o_n_weight_bit(n_weight_bit),
        .o_n_state_bit(n_state_bit), .o_n_start(n_start), .o_n_threshold(n_threshold),
        .i_n_state_bit_out(n_sbo), .i_n_fire_event(n_fire)
    );

    // Behavioural neuron: HDC mode XORs (fire is noise), SNN mode fires when the
    // accumulated weight&state count reaches threshold, then restarts the count.
    logic [L-1:0] p_vld = '0, p_sbo = '0, p_fire = '0;
    logic junk_s = 1'b0, junk_f = 1'b0;
    int   acc = 0;
    always @(posedge clk) begin : stub
        logic r_s, r_f;
        r_s = 1'b0;
        r_f = 1'b0;
        if (n_start) acc = 0;
        if (n_in_valid) begin
            if (n_mode_hdc) begin
                r_s = n_weight_bit ^ n_state_bit;
                r_f = n_weight_bit & n_state_bit;
            end else begin
                r_s = n_weight_bit | n_state_bit;
                acc += int'(n_weight_bit & n_state_bit);
                if (acc >= int'(n_threshold)) begin r_f = 1'b1; acc = 0; end
            end
        end
        junk_s <= 1'($urandom);
        junk_f <= 1'($urandom);
        p_vld  <= {p_vld[L-2:0], n_in_valid};
        p_sbo  <= {p_sbo[L-2:0], r_s};
        p_fire <= {p_fire[L-2:0], r_f};
    end
    assign n_sbo  = p_vld[L-1] ? p_sbo[L-1]  : junk_s;
    assign n_fire = p_vld[L-1] ? p_fire[L-1] : junk_f;

    typedef struct {
        logic [HV_DIM-1:0] hv;
        int cnt;
        int len;
        int starts;
        int due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0, cyc = 0;
    bit   cur_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [HV_DIM-1:0] act, input logic [HV_DIM-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit op, input logic [HV_DIM-1:0] a, input logic [HV_DIM-1:0] b,
                                   input int len, input int thr);
        exp_t e;
        int   eff, cnt_acc;
        eff = (op == 1'b0 || len == 0 || len > HV_DIM) ? HV_DIM : len;
        e.hv = '0; e.cnt = 0; e.len = eff; e.starts = op ? 1 : 0; e.due = 0;
        cnt_acc = 0;
        for (int k = 0; k < eff; k++) begin
            if (!op) e.hv[k] = a[k] ^ b[k];
            else begin
                cnt_acc += int'(a[k] & b[k]);
                if (cnt_acc >= thr) begin e.hv[k] = 1'b1; e.cnt++; cnt_acc = 0; end
            end
        end
        return e;
    endfunction

    task automatic push_exp(input bit op, input logic [HV_DIM-1:0] a, input logic [HV_DIM-1:0] b,
                            input int len, input int thr, input int t_acc);
        exp_t e;
        e = model(op, a, b, len, thr);
        e.due = t_acc + e.len + L + 2;
        sb.push_back(e);
        cur_mode = !op;
    endtask

    task automatic drive_cmd(input bit op, input logic [HV_DIM-1:0] a, input logic [HV_DIM-1:0] b,
                             input int len, input int thr);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_len = LEN_W'(len); bus.cmd_threshold = TW'(thr);
    endtask

    task automatic send_cmd(input bit op, input logic [HV_DIM-1:0] a, input logic [HV_DIM-1:0] b,
                            input int len, input int thr, output int t_acc);
        bit ok;
        ok = 1'b0;
        t_acc = -1;
        @(posedge clk); #1;
        drive_cmd(op, a, b, len, thr);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin ok = 1'b1; t_acc = cyc; end
        end
        check("cmd_accepted", ok, 1);
        if (ok) push_exp(op, a, b, len, thr, t_acc);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_job();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom % 3 != 0);
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) done = 1'b1;
        end
        check("rsp_handshake", done, 1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    // Monitor: latency on first rsp_valid, data on handshake, neuron-side protocol every cycle.
    int   iv_cnt = 0, st_cnt = 0;
    bit   prev_rv = 1'b0, prev_mode = 1'b0, acc_prev = 1'b0, prev_rst = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (n_in_valid) begin
            iv_cnt++;
            check("mode_in_stream", n_mode_hdc, cur_mode);
        end
        if (n_start) st_cnt++;
        if (n_mode_hdc !== prev_mode && prev_rst) check("mode_change_at_accept", acc_prev, 1);
        if (bus.rsp_valid && !prev_rv) begin
            if (sb.size() == 0) check("unexpected_rsp", bus.rsp_valid, 0);
            else                check("rsp_latency", cyc, sb[0].due);
        end
        if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
            cur = sb.pop_front();
            check("rsp_hv", bus.rsp_hv, cur.hv);
            check("rsp_fire_cnt", bus.rsp_fire_cnt, cur.cnt);
            check("in_valid_cycles", iv_cnt, cur.len);
            check("start_pulses", st_cnt, cur.starts);
        end
        acc_prev = bus.cmd_valid && bus.cmd_ready;
        if (acc_prev) begin iv_cnt = 0; st_cnt = 0; end
        prev_rv   = bus.rsp_valid;
        prev_mode = n_mode_hdc;
        prev_rst  = rst_n;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_n_in_valid"}, n_in_valid, 0);
        check({tag, "_n_start"}, n_start, 0);
        check({tag, "_n_mode_hdc"}, n_mode_hdc, 0);
        check({tag, "_n_weight_state"}, {n_weight_bit, n_state_bit}, 0);
        check({tag, "_n_threshold"}, n_threshold, 0);
        check({tag, "_rsp_hv"}, bus.rsp_hv, 0);
        check({tag, "_rsp_fire_cnt"}, bus.rsp_fire_cnt, 0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    initial begin
        int t;
        bit ok;
        logic [HV_DIM-1:0] ra, rb;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_len = '0; bus.cmd_threshold = '0; bus.abort = 1'b0; bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready_low", bus.cmd_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // BIND of a fixed pair, latency checked by the monitor
        send_cmd(1'b0, 64'hDEADBEEF_01234567, 64'h0F0F0F0F_F0F0F0F0, 0, 0, t);
        finish_job();

        // INTEGRATE, 20 bits of all-ones, threshold 10
        send_cmd(1'b1, '1, '1, 20, 10, t);
        finish_job();

        // INTEGRATE then BIND back to back
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        send_cmd(1'b1, ra, rb, 33, 3, t);
        finish_job();
        send_cmd(1'b0, 64'd1, 64'd0, 0, 0, t);
        finish_job();

        // Response backpressure with a second command waiting
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        send_cmd(1'b0, ra, rb, 0, 0, t);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = bus.rsp_valid; end
        check("bp_rsp_seen", ok, 1);
        @(posedge clk); #1;
        drive_cmd(1'b1, '1, 64'hFFFF_0000_FFFF_0000, 40, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.rsp_valid, 1);
            if (sb.size() > 0) check("bp_hold_hv", bus.rsp_hv, sb[0].hv);
            check("bp_cmd_ready_low", bus.cmd_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_accept_at_handshake", bus.cmd_ready, 0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_accept_next_cycle", bus.cmd_ready, 1);
        if (bus.cmd_ready) push_exp(1'b1, '1, 64'hFFFF_0000_FFFF_0000, 40, 2, cyc);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        finish_job();

        // Abort at stream bit 30
        send_cmd(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, t);
        repeat (31) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        check("abort_pre_streaming", n_in_valid, 1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        check("abort_in_valid_low", n_in_valid, 0);
        check("abort_idle", busy, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_rsp", bus.rsp_valid, 0);
        end
        send_cmd(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, t);
        finish_job();
        send_cmd(1'b1, '1, {$urandom, $urandom}, 12, 1, t);
        finish_job();

        // Reset pulse in the middle of DRAIN (len 5: DRAIN is 3 cycles)
        send_cmd(1'b1, '1, '1, 5, 2, t);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_drain_busy", busy, 1);
        check("rst_cmd_ready_low", bus.cmd_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        check_reset_outputs("rst_mid");

        // Randomized jobs: lengths include 0 and out-of-range values
        for (int j = 0; j < 24; j++) begin
            send_cmd(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 6)), t);
            finish_job();
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
